// File: rtl/log_scale_fp16_div.sv
// log_scale_fp16_div: FP16 divider working in the log2 domain.
// log2 via RAM table, subtract, exp2 via RAM table; 4-cycle latency.
module log_scale_fp16_div #(
  parameter int FLOAT_LEN = 16,
  parameter int EXP_LEN   = 5,
  parameter int MANT_LEN  = 10,
  parameter int LUT_SIZE  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  input  logic                 lut_wr_en,
  input  logic [MANT_LEN-1:0]  log2_lut_data_in,
  input  logic [FLOAT_LEN-1:0] exp2_lut_data_in,
  output logic [FLOAT_LEN-1:0] result
);

  localparam int IDX  = $clog2(LUT_SIZE);
  localparam int LW   = 18;
  localparam int NW   = LW - MANT_LEN;
  localparam int RW   = NW + 2;
  localparam int PADW = LW - EXP_LEN - MANT_LEN;
  localparam int EHI  = FLOAT_LEN - 2;
  localparam int BIAS = (1 << (EXP_LEN - 1)) - 1;

  localparam logic [LW-1:0] BIAS_FX =
    LW'(BIAS << MANT_LEN);
  localparam logic [EXP_LEN-1:0] EXP_MAX = '1;
  localparam logic signed [RW-1:0] RE_MAX =
    RW'((1 << EXP_LEN) - 1);
  localparam logic signed [RW-1:0] RE_MIN = '0;
  localparam logic [FLOAT_LEN-1:0] QNAN =
    {1'b0, EXP_MAX, 1'b1, {(MANT_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    SP_NUM,
    SP_ZERO,
    SP_INF,
    SP_NAN
  } sp_t;

  typedef struct packed {
    logic          v;
    logic          sg;
    sp_t           sp;
    logic [LW-1:0] la;
    logic [LW-1:0] lb;
  } s1_t;

  typedef struct packed {
    logic                 v;
    logic                 sg;
    sp_t                  sp;
    logic [NW-1:0]        n;
    logic [FLOAT_LEN-1:0] e;
  } s2_t;

  logic [MANT_LEN-1:0]  log2_lut [LUT_SIZE];
  logic [FLOAT_LEN-1:0] exp2_lut [LUT_SIZE];
  logic [IDX-1:0]       wp;

  logic [FLOAT_LEN-1:0] a_q, b_q;
  logic                 v0;
  s1_t                  s1_d, s1_q;
  s2_t                  s2_d, s2_q;
  sp_t                  ca, cb;
  logic [LW-1:0]        d_c;
  logic signed [RW-1:0] re_c;
  logic [FLOAT_LEN-1:0] r_c;
  logic                 unused_bits;

  function automatic sp_t classify(
    input logic [FLOAT_LEN-1:0] x
  );
    sp_t c;
    c = SP_NUM;
    unique case (1'b1)
      x[EHI -: EXP_LEN] == '0:
        c = SP_ZERO;
      x[EHI -: EXP_LEN] == EXP_MAX &&
      x[MANT_LEN-1:0] != '0:
        c = SP_NAN;
      x[EHI -: EXP_LEN] == EXP_MAX &&
      x[MANT_LEN-1:0] == '0:
        c = SP_INF;
      default:
        c = SP_NUM;
    endcase
    return c;
  endfunction

  // Serial table load; reads elsewhere see the old word on a write edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
    end else if (lut_wr_en) begin
      log2_lut[wp] <= log2_lut_data_in;
      exp2_lut[wp] <= exp2_lut_data_in;
      wp <= wp + 1'b1;
    end
  end

  // Log stage: classify operands and look up fixed-point log2
  always_comb begin
    s1_d = '0;
    ca = classify(a_q);
    cb = classify(b_q);
    s1_d.v = v0;
    s1_d.sg = a_q[FLOAT_LEN-1] ^ b_q[FLOAT_LEN-1];
    if (ca == SP_NAN || cb == SP_NAN ||
        (ca == SP_ZERO && cb == SP_ZERO) ||
        (ca == SP_INF && cb == SP_INF))
      s1_d.sp = SP_NAN;
    else if (ca == SP_INF || cb == SP_ZERO)
      s1_d.sp = SP_INF;
    else if (ca == SP_ZERO || cb == SP_INF)
      s1_d.sp = SP_ZERO;
    else
      s1_d.sp = SP_NUM;
    s1_d.la = {{PADW{1'b0}}, a_q[EHI -: EXP_LEN],
      log2_lut[a_q[MANT_LEN-1 -: IDX]]} - BIAS_FX;
    s1_d.lb = {{PADW{1'b0}}, b_q[EHI -: EXP_LEN],
      log2_lut[b_q[MANT_LEN-1 -: IDX]]} - BIAS_FX;
  end

  // Exp stage: split the log difference and look up 2^frac
  always_comb begin
    s2_d = '0;
    d_c = s1_q.la - s1_q.lb;
    s2_d.v = s1_q.v;
    s2_d.sg = s1_q.sg;
    s2_d.sp = s1_q.sp;
    s2_d.n = d_c[LW-1:MANT_LEN];
    s2_d.e = exp2_lut[d_c[MANT_LEN-1 -: IDX]];
  end

  // Output stage: rebias exponent, clamp range, apply specials
  always_comb begin
    r_c = '0;
    re_c = RW'($signed({1'b0, s2_q.e[EHI -: EXP_LEN]}))
         + RW'($signed(s2_q.n));
    unique case (s2_q.sp)
      SP_NAN:  r_c = QNAN;
      SP_INF:  r_c = {s2_q.sg, EXP_MAX,
                      {MANT_LEN{1'b0}}};
      SP_ZERO: r_c = {s2_q.sg, {(FLOAT_LEN-1){1'b0}}};
      default: begin
        if (re_c >= RE_MAX)
          r_c = {s2_q.sg, EXP_MAX, {MANT_LEN{1'b0}}};
        else if (re_c <= RE_MIN)
          r_c = {s2_q.sg, {(FLOAT_LEN-1){1'b0}}};
        else
          r_c = {s2_q.sg, re_c[EXP_LEN-1:0],
                 s2_q.e[MANT_LEN-1:0]};
      end
    endcase
  end

  // Pipeline registers; reset drops every in-flight operand
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      v0     <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      result <= '0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      v0     <= 1'b1;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      result <= s2_q.v ? r_c : '0;
    end
  end

  assign unused_bits = ^{a_q[MANT_LEN-IDX-1:0],
                         b_q[MANT_LEN-IDX-1:0],
                         d_c[MANT_LEN-IDX-1:0],
                         s2_q.e[FLOAT_LEN-1]};

endmodule

// File: tb/tb_log_scale_fp16_div.sv
// tb_log_scale_fp16_div: vector table, corner sequences and
// random streaming against a quotient model and 1.1% bound.
module tb_log_scale_fp16_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        lut_wr_en;
  logic [9:0]  log2_lut_data_in;
  logic [15:0] exp2_lut_data_in;
  logic [15:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int lt [128];
  int et [128];

  localparam int NRAND = 1000;
  localparam int NVEC  = 16;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        exact;
    logic [15:0] want;
  } vec_t;

  vec_t        vt [NVEC];
  logic [15:0] pa [NRAND];
  logic [15:0] pb [NRAND];

  always #5 clk = ~clk;

  log_scale_fp16_div dut (
    .clk              (clk),
    .rst              (rst),
    .a                (a),
    .b                (b),
    .lut_wr_en        (lut_wr_en),
    .log2_lut_data_in (log2_lut_data_in),
    .exp2_lut_data_in (exp2_lut_data_in),
    .result           (result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real fp16_to_real(input logic [15:0] x);
    int  e;
    real v;
    e = int'(x[14:10]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(int'(x[9:0])) / 1024.0;
    for (int k = 15; k < e; k++) v = v * 2.0;
    for (int k = e; k < 15; k++) v = v / 2.0;
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real x);
    logic s;
    real  v, sc, fr;
    int   e, r;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    sc = (v - 1.0) * 1024.0;
    r = $rtoi(sc);
    fr = sc - real'(r);
    if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r++;
    if (r == 1024) begin r = 0; e++; end
    return {s, 5'(e), 10'(r)};
  endfunction

  // Quotient from the table method, in integer fixed point
  function automatic logic [15:0] model(
    input logic [15:0] x, input logic [15:0] y
  );
    int  ex, ey, la, lb, d, n, f, ev, re;
    logic s;
    logic za, zb, ia, ib, qa, qb;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    s  = x[15] ^ y[15];
    za = (ex == 0);
    zb = (ey == 0);
    ia = (ex == 31) && (x[9:0] == 0);
    ib = (ey == 31) && (y[9:0] == 0);
    qa = (ex == 31) && (x[9:0] != 0);
    qb = (ey == 31) && (y[9:0] != 0);
    if (qa || qb || (za && zb) || (ia && ib))
      return 16'h7E00;
    if (ia || zb) return {s, 15'h7C00};
    if (za || ib) return {s, 15'h0000};
    la = (ex - 15) * 1024 + lt[int'(x[9:0]) / 8];
    lb = (ey - 15) * 1024 + lt[int'(y[9:0]) / 8];
    d = la - lb;
    n = (d >= 0) ? d / 1024 : -((-d + 1023) / 1024);
    f = d - n * 1024;
    ev = et[f / 8];
    re = ((ev >> 10) % 32) + n;
    if (re >= 31) return {s, 15'h7C00};
    if (re <= 0) return {s, 15'h0000};
    return {s, 5'(re), 10'(ev % 1024)};
  endfunction

  task automatic check_bits(
    input string nm, input int idx,
    input logic [15:0] got, input logic [15:0] want
  );
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: result=%h required=%h",
               nm, idx, got, want);
    end
  endtask

  task automatic check_near(
    input string nm, input int idx,
    input logic [15:0] got, input real q
  );
    real rv, err;
    n_tests++;
    rv = fp16_to_real(got);
    err = rv - q;
    if (err < 0.0) err = -err;
    if (got[14:10] == 5'h1f ||
        err > 0.011 * (q < 0.0 ? -q : q)) begin
      n_fail++;
      $display("FAIL %s[%0d]: result=%h (%f) required %f +-1.1%%",
               nm, idx, got, rv, q);
    end
  endtask

  task automatic idle();
    a = 16'h0000;
    b = 16'h4000;
  endtask

  initial begin
    real v, q;
    int  idx;

    for (int i = 0; i < 128; i++) begin
      v = 1.0 + (real'(i) + 0.5) / 128.0;
      lt[i] = $rtoi($ln(v) / $ln(2.0) * 1024.0 + 0.5);
      v = $pow(2.0, (real'(i) + 0.5) / 128.0);
      et[i] = (15 << 10) + $rtoi((v - 1.0) * 1024.0 + 0.5);
    end

    vt[0]  = '{16'h4500, 16'h4000, 1'b0, 16'h0000};
    vt[1]  = '{16'hC0D7, 16'h48D0, 1'b0, 16'h0000};
    vt[2]  = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000};
    vt[3]  = '{16'h0000, 16'h4500, 1'b1, 16'h0000};
    vt[4]  = '{16'h4500, 16'h0000, 1'b1, 16'h7C00};
    vt[5]  = '{16'hC500, 16'h0000, 1'b1, 16'hFC00};
    vt[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h7E00};
    vt[7]  = '{16'h7C00, 16'h4000, 1'b1, 16'h7C00};
    vt[8]  = '{16'h7BFF, 16'h1400, 1'b1, 16'h7C00};
    vt[9]  = '{16'h0400, 16'h7BFF, 1'b1, 16'h0000};
    vt[10] = '{16'h7E00, 16'h4000, 1'b1, 16'h7E00};
    vt[11] = '{16'h7C00, 16'hFC00, 1'b1, 16'h7E00};
    vt[12] = '{16'h4000, 16'hFC00, 1'b1, 16'h8000};
    vt[13] = '{16'h8001, 16'h4000, 1'b1, 16'h8000};
    vt[14] = '{16'h4000, 16'h0001, 1'b1, 16'h7C00};
    vt[15] = '{16'hC500, 16'h4500, 1'b0, 16'h0000};

    for (int i = 0; i < NRAND; i++) begin
      pa[i] = real_to_fp16(
        real'(int'($urandom_range(19998)) - 9999) * 0.001);
      pb[i] = real_to_fp16(
        real'(int'($urandom_range(19998)) - 9999) * 0.001);
    end

    rst = 1'b1;
    lut_wr_en = 1'b0;
    log2_lut_data_in = '0;
    exp2_lut_data_in = '0;
    a = 16'h4500;
    b = 16'h4000;
    tick();
    check_bits("reset", 0, result, 16'h0000);
    tick();
    check_bits("reset", 1, result, 16'h0000);
    rst = 1'b0;
    idle();

    for (int i = 0; i < 128; i++) begin
      lut_wr_en = 1'b1;
      log2_lut_data_in = 10'(lt[i]);
      exp2_lut_data_in = 16'(et[i]);
      tick();
    end
    lut_wr_en = 1'b0;
    check_bits("load_idle", 0, result, 16'h0000);

    lut_wr_en = 1'b1;
    log2_lut_data_in = 10'd0;
    exp2_lut_data_in = 16'h3E00;
    tick();
    lut_wr_en = 1'b0;
    a = 16'h3C00;
    b = 16'h3C00;
    tick();
    idle();
    tick();
    tick();
    tick();
    check_bits("wrap", 0, result, 16'h3E00);

    for (int k = 0; k < 128; k++) begin
      idx = (1 + k) % 128;
      lut_wr_en = 1'b1;
      log2_lut_data_in = 10'(lt[idx]);
      exp2_lut_data_in = 16'(et[idx]);
      tick();
    end
    lut_wr_en = 1'b0;
    a = 16'h3C00;
    b = 16'h3C00;
    tick();
    idle();
    tick();
    tick();
    tick();
    check_bits("reload", 0, result,
               model(16'h3C00, 16'h3C00));

    for (int i = 0; i < NVEC + 3; i++) begin
      if (i < NVEC) begin
        a = vt[i].a;
        b = vt[i].b;
      end else begin
        idle();
      end
      tick();
      if (i >= 3) begin
        if (vt[i-3].exact) begin
          check_bits("vec", i - 3, result, vt[i-3].want);
        end else begin
          q = fp16_to_real(vt[i-3].a)
            / fp16_to_real(vt[i-3].b);
          check_near("vec", i - 3, result, q);
        end
      end
    end

    idle();
    tick();
    tick();
    tick();
    tick();
    a = 16'h4500;
    b = 16'h4000;
    tick();
    idle();
    tick();
    tick();
    check_bits("latency_k2", 0, result, 16'h0000);
    tick();
    check_bits("latency_k3", 0, result,
               model(16'h4500, 16'h4000));
    tick();
    check_bits("latency_k4", 0, result, 16'h0000);

    a = 16'h4500;
    b = 16'h4000;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check_bits("midrst", 0, result, 16'h0000);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_bits("midrst", i, result, 16'h0000);
    end
    tick();
    check_bits("midrst", 4, result,
               model(16'h4500, 16'h4000));

    for (int i = 0; i < NRAND + 3; i++) begin
      if (i < NRAND) begin
        a = pa[i];
        b = pb[i];
      end else begin
        idle();
      end
      tick();
      if (i >= 3) begin
        check_bits("stream", i - 3, result,
                   model(pa[i-3], pb[i-3]));
        if (pa[i-3][14:10] != 0 && pb[i-3][14:10] != 0) begin
          q = fp16_to_real(pa[i-3])
            / fp16_to_real(pb[i-3]);
          check_near("stream_acc", i - 3, result, q);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
